// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: one aligned 64-bit bus transaction per op,
// with lane formatting on both directions and a response timeout.
module ysyx_22050612_lsu #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_wen,
  output logic [4:0]  out_rd,
  output logic [63:0] out_data,
  output logic        out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wen_q, wen_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic          owen_q, owen_d;
  logic [63:0]   odata_q, odata_d;
  logic          oerr_q, oerr_d;
  logic [4:0]    ord_q, ord_d;

  logic          misal;
  logic [5:0]    shift;
  logic [7:0]    bmask;
  logic [63:0]   rsh;
  logic [63:0]   rfmt;
  logic          ld_wen;

  always_comb begin
    misal = 1'b0;
    unique case (in_size)
      2'd0: misal = 1'b0;
      2'd1: misal = in_addr[0];
      2'd2: misal = |in_addr[1:0];
      2'd3: misal = |in_addr[2:0];
    endcase
  end

  assign shift = {addr_q[2:0], 3'b000};
  assign rsh   = mem_rsp_data >> shift;

  always_comb begin
    bmask = 8'h00;
    rfmt  = 64'd0;
    unique case (size_q)
      2'd0: begin
        bmask = 8'h01;
        rfmt  = {{56{rsh[7] & ~uns_q}}, rsh[7:0]};
      end
      2'd1: begin
        bmask = 8'h03;
        rfmt  = {{48{rsh[15] & ~uns_q}}, rsh[15:0]};
      end
      2'd2: begin
        bmask = 8'h0F;
        rfmt  = {{32{rsh[31] & ~uns_q}}, rsh[31:0]};
      end
      2'd3: begin
        bmask = 8'hFF;
        rfmt  = rsh;
      end
    endcase
  end

  assign ld_wen = !wen_q && (rd_q != 5'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    owen_d  = owen_q;
    odata_d = odata_q;
    oerr_d  = oerr_q;
    ord_d   = ord_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wen_d   = in_wen;
          size_d  = in_size;
          uns_d   = in_unsigned;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          rd_d    = in_rd;
          if (misal) begin
            state_d = S_DONE;
            owen_d  = 1'b0;
            odata_d = 64'd0;
            oerr_d  = 1'b1;
            ord_d   = in_rd;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // a response on the expiry edge still completes normally
        if (mem_rsp_valid) begin
          state_d = S_DONE;
          owen_d  = ld_wen;
          odata_d = ld_wen ? rfmt : 64'd0;
          oerr_d  = 1'b0;
          ord_d   = rd_q;
        end else if (cnt_q == TMAX) begin
          state_d = S_DONE;
          owen_d  = 1'b0;
          odata_d = 64'd0;
          oerr_d  = 1'b1;
          ord_d   = rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          owen_d  = 1'b0;
          odata_d = 64'd0;
          oerr_d  = 1'b0;
          ord_d   = 5'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rd_q    <= 5'd0;
      owen_q  <= 1'b0;
      odata_q <= 64'd0;
      oerr_q  <= 1'b0;
      ord_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      owen_q  <= owen_d;
      odata_q <= odata_d;
      oerr_q  <= oerr_d;
      ord_q   <= ord_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE) && !rst;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = mem_req_valid ? {addr_q[63:3], 3'b000} : 64'd0;
  assign mem_req_wen   = mem_req_valid && wen_q;
  assign mem_req_wmask = mem_req_wen ? (bmask << addr_q[2:0]) : 8'h00;
  assign mem_req_wdata = mem_req_wen ? (wdata_q << shift) : 64'd0;
  assign out_valid     = (state_q == S_DONE);
  assign out_wen       = owen_q;
  assign out_rd        = ord_q;
  assign out_data      = odata_q;
  assign out_err       = oerr_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Directed bench for the load/store unit: vector table plus
// hand-written backpressure, timeout and reset sequences.
module tb_ysyx_22050612_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_wen;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic        out_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22050612_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wen(out_wen), .out_rd(out_rd),
    .out_data(out_data), .out_err(out_err)
  );

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rsp;
    logic        mis;
    logic [63:0] e_addr;
    logic [7:0]  e_mask;
    logic [63:0] e_wdata;
    logic        e_wen;
    logic [63:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    @(negedge clk);
    in_valid    = 1'b1;
    in_wen      = t.wen;
    in_size     = t.size;
    in_unsigned = t.uns;
    in_addr     = t.addr;
    in_wdata    = t.wdata;
    in_rd       = t.rd;
  endtask

  task automatic run_op(input vec_t t, input string nm);
    drive(t);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    if (t.mis) begin
      chk({nm, "_noreq"}, 64'(mem_req_valid), 64'd0);
    end else begin
      chk({nm, "_req_valid"}, 64'(mem_req_valid), 64'd1);
      chk({nm, "_req_addr"}, mem_req_addr, t.e_addr);
      chk({nm, "_req_wen"}, 64'(mem_req_wen), 64'(t.wen));
      chk({nm, "_wmask"}, 64'(mem_req_wmask), 64'(t.e_mask));
      chk({nm, "_wdata"}, mem_req_wdata, t.e_wdata);
      tick();
      chk({nm, "_req_drop"}, 64'(mem_req_valid), 64'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = t.rsp;
      tick();
      mem_rsp_valid = 1'b0;
    end
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_out_wen"}, 64'(out_wen), 64'(t.e_wen));
    chk({nm, "_out_data"}, out_data, t.e_data);
    chk({nm, "_out_err"}, 64'(out_err), 64'(t.e_err));
    chk({nm, "_out_rd"}, 64'(out_rd), 64'(t.rd));
    tick();
    chk({nm, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vec_t t;
    // wen size uns addr wdata rd rsp mis e_addr e_mask e_wdata e_wen e_data e_err
    v[0] = '{1'b0, 2'd0, 1'b0, 64'h8000_0005, 64'd0, 5'd5,
             64'h0011_8000_0000_0000, 1'b0, 64'h8000_0000, 8'h00,
             64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    v[1] = '{1'b0, 2'd0, 1'b1, 64'h8000_0005, 64'd0, 5'd5,
             64'h0011_8000_0000_0000, 1'b0, 64'h8000_0000, 8'h00,
             64'd0, 1'b1, 64'h80, 1'b0};
    v[2] = '{1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hABCD, 5'd7,
             64'd0, 1'b0, 64'h8000_0000, 8'hC0,
             64'hABCD_0000_0000_0000, 1'b0, 64'd0, 1'b0};
    v[3] = '{1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 5'd8,
             64'd0, 1'b1, 64'd0, 8'h00, 64'd0, 1'b0, 64'd0, 1'b1};
    v[4] = '{1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 5'd3,
             64'h8877_6655_4433_2211, 1'b0, 64'h8000_0010, 8'h00,
             64'd0, 1'b1, 64'h8877_6655_4433_2211, 1'b0};
    v[5] = '{1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 5'd10,
             64'h9ABC_DEF0_0000_0000, 1'b0, 64'h8000_0000, 8'h00,
             64'd0, 1'b1, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0};
    v[6] = '{1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 5'd10,
             64'h9ABC_DEF0_0000_0000, 1'b0, 64'h8000_0000, 8'h00,
             64'd0, 1'b1, 64'h0000_0000_9ABC_DEF0, 1'b0};
    v[7] = '{1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0, 5'd11,
             64'h0000_0000_8001_0000, 1'b0, 64'h8000_0000, 8'h00,
             64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
    v[8] = '{1'b1, 2'd3, 1'b0, 64'h8000_0008, 64'h0123_4567_89AB_CDEF,
             5'd0, 64'd0, 1'b0, 64'h8000_0008, 8'hFF,
             64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b0};
    v[9] = '{1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'hFF5A, 5'd2,
             64'd0, 1'b0, 64'h8000_0000, 8'h08,
             64'h0000_00FF_5A00_0000, 1'b0, 64'd0, 1'b0};
    v[10] = '{1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h55, 5'd1,
              64'd0, 1'b1, 64'd0, 8'h00, 64'd0, 1'b0, 64'd0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_wen = 1'b0; in_size = 2'd0;
    in_unsigned = 1'b0; in_addr = 64'd0; in_wdata = 64'd0;
    in_rd = 5'd0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    mem_rsp_data = 64'd0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_wmask", 64'(mem_req_wmask), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      run_op(v[i], $sformatf("vec%0d", i));
    end

    // backpressure on both sides
    t = v[4];
    t.addr = 64'h8000_0008;
    t.rd = 5'd9;
    t.rsp = 64'h1122_3344_5566_7788;
    mem_req_ready = 1'b0;
    out_ready = 1'b0;
    drive(t);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", 64'(mem_req_valid), 64'd1);
      chk("bp_req_addr", mem_req_addr, 64'h8000_0008);
      chk("bp_req_wmask", 64'(mem_req_wmask), 64'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    chk("bp_req_hold", 64'(mem_req_valid), 64'd1);
    tick();
    chk("bp_req_drop", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'h1122_3344_5566_7788;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data", out_data, 64'h1122_3344_5566_7788);
      chk("bp_out_wen", 64'(out_wen), 64'd1);
      if (i == 3) out_ready = 1'b1;
      tick();
    end
    chk("bp_single_wb", 64'(out_valid), 64'd0);

    // timeout with no response
    t = v[5];
    t.addr = 64'h8000_0000;
    t.rd = 5'd4;
    out_ready = 1'b0;
    drive(t);
    tick();
    in_valid = 1'b0;
    chk("to_req_valid", 64'(mem_req_valid), 64'd1);
    tick();
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("to_not_yet", 64'(out_valid), 64'd0);
    end
    tick();
    chk("to_out_valid", 64'(out_valid), 64'd1);
    chk("to_out_err", 64'(out_err), 64'd1);
    chk("to_out_wen", 64'(out_wen), 64'd0);
    chk("to_out_data", out_data, 64'd0);
    out_ready = 1'b1;
    tick();
    chk("to_idle", 64'(in_ready), 64'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'hDEAD;
    tick();
    mem_rsp_valid = 1'b0;
    chk("idle_rsp_ignored", 64'(out_valid), 64'd0);
    chk("idle_rsp_noreq", 64'(mem_req_valid), 64'd0);
    tick();
    chk("idle_rsp_ignored2", 64'(out_valid), 64'd0);

    // response on the expiry edge wins
    drive(v[4]);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data = v[4].rsp;
    tick();
    mem_rsp_valid = 1'b0;
    chk("edge_out_valid", 64'(out_valid), 64'd1);
    chk("edge_out_err", 64'(out_err), 64'd0);
    chk("edge_out_data", out_data, v[4].rsp);
    tick();

    // reset during WAIT
    drive(v[4]);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rw_in_ready", 64'(in_ready), 64'd1);
    chk("rw_out_valid", 64'(out_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'h1234;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rw_late_rsp", 64'(out_valid), 64'd0);
    chk("rw_late_rsp_rdy", 64'(in_ready), 64'd1);

    // reset during REQ drops the request
    mem_req_ready = 1'b0;
    drive(v[4]);
    tick();
    in_valid = 1'b0;
    chk("rr_req_valid", 64'(mem_req_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_req_drop", 64'(mem_req_valid), 64'd0);
    mem_req_ready = 1'b1;

    // load with rd=0 must not write back
    t = v[4];
    t.rd = 5'd0;
    t.e_wen = 1'b0;
    t.e_data = 64'd0;
    run_op(t, "ld_rd0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
